// File: rtl/mem_arbiter.sv
// Arbiter between an I-cache (read only) and a D-cache (read/write-back) for one block-wide memory port.
// Build option ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed D-cache priority.
module mem_arbiter #(
    parameter int Word_Size  = 32,
    parameter int Block_Size = 4,
    parameter int Timeout    = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_rd,
    input  logic                            d_rd,
    input  logic                            d_wr,
    input  logic [31:0]                     i_addr,
    input  logic [31:0]                     d_addr,
    input  logic [Word_Size*Block_Size-1:0] d_wdata,
    output logic                            i_ack,
    output logic                            d_ack,
    output logic [Word_Size*Block_Size-1:0] rdata,
    output logic                            err,
    output logic                            mem_rd,
    output logic                            mem_wr,
    output logic [31:0]                     mem_addr,
    output logic [Word_Size*Block_Size-1:0] mem_wdata,
    input  logic [Word_Size*Block_Size-1:0] mem_rdata,
    input  logic                            mem_ready
);

    localparam logic [7:0] TMO_LIMIT = 8'(Timeout);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        grant_d;
    logic        rd_pending;
    logic        err_q;
    logic [7:0]  tmo_cnt;

    logic        pend_i;
    logic        pend_d;
    logic        pick_d;
    logic        grant;
    logic        tmo_hit;
    logic        capture;
    logic        tmo_clr;
    logic        tmo_inc;
    logic        set_err;

    assign pend_i  = i_rd;
    assign pend_d  = d_rd | d_wr;
    assign tmo_hit = (tmo_cnt + 8'd1) == TMO_LIMIT;

`ifdef ARB_ROUND_ROBIN_EN
    // last_d remembers who won the previous grant; on a tie the other side wins
    logic last_d;

    assign pick_d = pend_d & (~pend_i | ~last_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (grant) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = pend_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        capture    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                if (pend_i | pend_d) begin
                    grant      = 1'b1;
                    tmo_clr    = 1'b1;
                    state_next = (pick_d && d_wr) ? WRITE : READ;
                end
            end
            READ: begin
                if (mem_ready) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else if (tmo_hit) begin
                    set_err    = 1'b1;
                    state_next = RESP;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            WRITE: begin
                // A write-back paired with a refill continues into READ at the same address
                if (mem_ready) begin
                    if (rd_pending) begin
                        tmo_clr    = 1'b1;
                        state_next = READ;
                    end else begin
                        state_next = RESP;
                    end
                end else if (tmo_hit) begin
                    set_err    = 1'b1;
                    state_next = RESP;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            grant_d    <= 1'b0;
            rd_pending <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (grant) begin
                mem_addr   <= pick_d ? d_addr : i_addr;
                mem_wdata  <= pick_d ? d_wdata : '0;
                grant_d    <= pick_d;
                rd_pending <= pick_d ? d_rd : 1'b1;
                err_q      <= 1'b0;
            end
            if (capture) begin
                rdata <= mem_rdata;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tmo_clr) begin
            tmo_cnt <= 8'd0;
        end else if (tmo_inc) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign mem_rd = (state == READ);
    assign mem_wr = (state == WRITE);
    assign i_ack  = (state == RESP) && !grant_d;
    assign d_ack  = (state == RESP) && grant_d;
    assign err    = (state == RESP) && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration and memory.
module tb_mem_arbiter;

    localparam int WS  = 32;
    localparam int BS  = 4;
    localparam int BW  = WS * BS;
    localparam int TMO = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [31:0]   i_addr;
    logic [31:0]   d_addr;
    logic [BW-1:0] d_wdata;
    logic          i_ack;
    logic          d_ack;
    logic [BW-1:0] rdata;
    logic          err;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_addr;
    logic [BW-1:0] mem_wdata;
    logic [BW-1:0] mem_rdata;
    logic          mem_ready;

    int            tests_run;
    int            failures;
    int            cyc;

    logic          busy;
    logic          ack_due;
    logic          ack_err;
    logic          phase_read;
    logic          win_d;
    logic          win_rd;
    logic          win_wr;
    logic [31:0]   win_addr;
    logic [BW-1:0] win_wdata;
    logic          last_d_model;
    logic [BW-1:0] model_rdata;
    int            lat;
    int            wait_cnt;
    int            strobe_cycles;
    int            fixed_lat;
    logic          never_ready;
    int            i_repeat;
    int            d_repeat;
    int            last_ack_cycle;
    logic          last_ack_err;
    int            obs_rd_cycles;
    int            req_cyc;
    int            op;
    bit            grant_q[$];
    logic [BW-1:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter #(
        .Word_Size (WS),
        .Block_Size(BS),
        .Timeout   (TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_rd     (i_rd),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .i_addr   (i_addr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .i_ack    (i_ack),
        .d_ack    (d_ack),
        .rdata    (rdata),
        .err      (err),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [BW-1:0] randBlock();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] randIAddr();
        return {4'h1, 24'($urandom()), 4'h0};
    endfunction

    // D-cache addresses come from a small pool so write-backs are later read again
    function automatic logic [31:0] randDAddr();
        return {4'h2, 24'($urandom_range(0, 7)), 4'h0};
    endfunction

    function automatic int newLatency();
        return (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    endfunction

    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic memFetch(input logic [31:0] a, output logic [BW-1:0] v);
        if (!mem_model.exists(a)) begin
            mem_model[a] = randBlock();
        end
        v = mem_model[a];
    endtask

    // One clock cycle: check the DUT against the model at the negedge, play memory, then advance
    task automatic applyStimulus();
        logic [BW-1:0] v;
        cyc++;
        if (ack_due) begin
            checkOutput("i_ack", BW'(i_ack), BW'(!win_d));
            checkOutput("d_ack", BW'(d_ack), BW'(win_d));
            checkOutput("err", BW'(err), BW'(ack_err));
            checkOutput("strobes_in_resp", BW'({mem_rd, mem_wr}), BW'(0));
            if (!ack_err && win_rd) begin
                if (win_wr) begin
                    v = win_wdata;
                end else begin
                    memFetch(win_addr, v);
                end
                checkOutput("rdata", rdata, v);
                model_rdata = v;
            end else begin
                checkOutput("rdata_hold", rdata, model_rdata);
            end
            grant_q.push_back(d_ack);
            last_ack_cycle = cyc;
            last_ack_err   = err;
            if (win_d) begin
                if (d_repeat > 0) begin
                    d_repeat--;
                    d_addr  = randDAddr();
                    d_wdata = randBlock();
                end else begin
                    d_rd = 1'b0;
                    d_wr = 1'b0;
                end
            end else begin
                if (i_repeat > 0) begin
                    i_repeat--;
                    i_addr = randIAddr();
                end else begin
                    i_rd = 1'b0;
                end
            end
            ack_due   = 1'b0;
            busy      = 1'b0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = randBlock();
        end else if (busy) begin
            checkOutput("mem_rd", BW'(mem_rd), BW'(phase_read));
            checkOutput("mem_wr", BW'(mem_wr), BW'(!phase_read));
            checkOutput("ack_while_busy", BW'({i_ack, d_ack}), BW'(0));
            checkOutput("mem_addr", BW'(mem_addr), BW'(win_addr));
            if (!phase_read) begin
                checkOutput("mem_wdata", mem_wdata, win_wdata);
            end
            if (mem_rd) begin
                obs_rd_cycles++;
            end
            strobe_cycles++;
            if (!never_ready && wait_cnt >= lat) begin
                mem_ready = 1'b1;
                if (mem_rd) begin
                    memFetch(mem_addr, v);
                    mem_rdata = v;
                end else begin
                    mem_rdata = randBlock();
                end
                if (mem_wr) begin
                    mem_model[mem_addr] = mem_wdata;
                end
                if (phase_read || !win_rd) begin
                    ack_due = 1'b1;
                end else begin
                    phase_read    = 1'b1;
                    wait_cnt      = 0;
                    strobe_cycles = 0;
                    lat           = newLatency();
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = randBlock();
                wait_cnt++;
                if (strobe_cycles == TMO) begin
                    ack_due = 1'b1;
                    ack_err = 1'b1;
                end
            end
        end else begin
            checkOutput("idle_acks", BW'({i_ack, d_ack}), BW'(0));
            checkOutput("idle_strobes", BW'({mem_rd, mem_wr}), BW'(0));
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = randBlock();
            if (i_rd || d_rd || d_wr) begin
                if ((d_rd || d_wr) && i_rd) begin
`ifdef ARB_ROUND_ROBIN_EN
                    win_d = !last_d_model;
`else
                    win_d = 1'b1;
`endif
                end else begin
                    win_d = d_rd || d_wr;
                end
                last_d_model  = win_d;
                win_addr      = win_d ? d_addr : i_addr;
                win_rd        = win_d ? d_rd : 1'b1;
                win_wr        = win_d ? d_wr : 1'b0;
                win_wdata     = d_wdata;
                phase_read    = !win_wr;
                busy          = 1'b1;
                ack_err       = 1'b0;
                wait_cnt      = 0;
                strobe_cycles = 0;
                lat           = newLatency();
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        i_rd      = 1'b0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        cyc++;
        reset        = 1'b0;
        busy         = 1'b0;
        ack_due      = 1'b0;
        ack_err      = 1'b0;
        last_d_model = 1'b0;
        model_rdata  = '0;
        i_repeat     = 0;
        d_repeat     = 0;
        checkOutput("rst_strobes", BW'({mem_rd, mem_wr}), BW'(0));
        checkOutput("rst_acks", BW'({i_ack, d_ack}), BW'(0));
        checkOutput("rst_err", BW'(err), BW'(0));
        checkOutput("rst_rdata", rdata, '0);
        checkOutput("rst_mem_addr", BW'(mem_addr), BW'(0));
        checkOutput("rst_mem_wdata", mem_wdata, '0);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((i_rd || d_rd || d_wr || busy || ack_due) && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("wait_budget", BW'(n < budget), BW'(1));
    endtask

    initial begin
        tests_run     = 0;
        failures      = 0;
        cyc           = 0;
        reset         = 1'b1;
        i_rd          = 1'b0;
        d_rd          = 1'b0;
        d_wr          = 1'b0;
        i_addr        = '0;
        d_addr        = '0;
        d_wdata       = '0;
        mem_ready     = 1'b0;
        mem_rdata     = '0;
        fixed_lat     = -1;
        never_ready   = 1'b0;
        obs_rd_cycles = 0;
        last_ack_err  = 1'b0;
        doReset();
        doReset();

        // Single I-cache refill with one wait state
        fixed_lat          = 1;
        mem_model[32'h10]  = {32{4'hA}};
        grant_q.delete();
        i_addr  = 32'h10;
        i_rd    = 1'b1;
        req_cyc = cyc + 1;
        waitIdle(50);
        checkOutput("req035_latency", BW'(last_ack_cycle - req_cyc), BW'(3));
        checkOutput("req035_rdata", rdata, {32{4'hA}});
        checkOutput("req035_err", BW'(last_ack_err), BW'(0));
        checkOutput("req035_ack_count", BW'(grant_q.size()), BW'(1));

        // D-cache write-back followed by refill of the same block
        fixed_lat     = 2;
        obs_rd_cycles = 0;
        grant_q.delete();
        d_addr  = 32'hFF0;
        d_wdata = BW'(32'h77);
        d_wr    = 1'b1;
        d_rd    = 1'b1;
        waitIdle(50);
        checkOutput("req036_rdata", rdata, BW'(32'h77));
        checkOutput("req036_rd_cycles", BW'(obs_rd_cycles), BW'(3));
        checkOutput("req036_single_d_ack", BW'(grant_q.size()), BW'(1));

        // Simultaneous requests for three rounds
        doReset();
        fixed_lat = 0;
        grant_q.delete();
        i_addr   = randIAddr();
        d_addr   = randDAddr();
        d_repeat = 2;
        i_rd     = 1'b1;
        d_rd     = 1'b1;
        waitIdle(100);
        checkOutput("req037_grants", BW'(grant_q.size()), BW'(4));
        if (grant_q.size() == 4) begin
`ifdef ARB_ROUND_ROBIN_EN
            checkOutput("req037_order", BW'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}), BW'(4'b1011));
`else
            checkOutput("req037_order", BW'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}), BW'(4'b1110));
`endif
        end

        // Refill that never completes, then a write+read that never completes
        never_ready   = 1'b1;
        obs_rd_cycles = 0;
        d_addr = randDAddr();
        d_rd   = 1'b1;
        waitIdle(100);
        checkOutput("req038_err", BW'(last_ack_err), BW'(1));
        checkOutput("req038_rd_cycles", BW'(obs_rd_cycles), BW'(TMO));
        obs_rd_cycles = 0;
        d_addr  = randDAddr();
        d_wdata = randBlock();
        d_wr    = 1'b1;
        d_rd    = 1'b1;
        waitIdle(100);
        checkOutput("wr_rd_tmo_err", BW'(last_ack_err), BW'(1));
        checkOutput("wr_rd_tmo_no_read", BW'(obs_rd_cycles), BW'(0));

        // Reset in the middle of a refill, then a normal refill
        i_addr = randIAddr();
        i_rd   = 1'b1;
        repeat (3) applyStimulus();
        doReset();
        never_ready = 1'b0;
        fixed_lat   = 0;
        grant_q.delete();
        i_addr = randIAddr();
        i_rd   = 1'b1;
        waitIdle(50);
        checkOutput("req039_after_reset", BW'(grant_q.size()), BW'(1));

        // D-cache request arriving while the I-cache is being served
        fixed_lat = 2;
        grant_q.delete();
        i_addr = randIAddr();
        i_rd   = 1'b1;
        applyStimulus();
        applyStimulus();
        d_addr = randDAddr();
        d_rd   = 1'b1;
        waitIdle(100);
        checkOutput("req040_grants", BW'(grant_q.size()), BW'(2));
        if (grant_q.size() == 2) begin
            checkOutput("req040_order", BW'({grant_q[0], grant_q[1]}), BW'(2'b01));
        end

        // Randomized traffic from both requesters with random memory latency
        fixed_lat = -1;
        for (int r = 0; r < 60; r++) begin
            if (!i_rd && $urandom_range(0, 1) == 1) begin
                i_addr = randIAddr();
                i_rd   = 1'b1;
            end
            if (!d_rd && !d_wr && $urandom_range(0, 1) == 1) begin
                op      = int'($urandom_range(1, 3));
                d_addr  = randDAddr();
                d_wdata = randBlock();
                d_rd    = op[0];
                d_wr    = op[1];
            end
            repeat ($urandom_range(1, 6)) applyStimulus();
        end
        waitIdle(500);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter Word_Size, 32, data word width in bits.
REQ-002 Parameter Block_Size, 4, words per cache block; block width BW = Word_Size*Block_Size (128 by default).
REQ-003 Parameter Timeout, 255, maximum cycles to wait for mem_ready; legal range 1..255, held in an 8-bit counter.
REQ-004 clk  input  1  single clock; all logic samples on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_rd / d_rd  input  1  I-cache / D-cache block read (refill) request.
REQ-007 d_wr  input  1  D-cache block write-back request; the I-cache has no write port.
REQ-008 i_addr / d_addr  input  32  block address of each requester.
REQ-009 d_wdata  input  BW  D-cache write-back block.
REQ-010 i_ack / d_ack  output  1  one-cycle completion pulse to each requester.
REQ-011 rdata  output  BW  read block, shared by both requesters; valid only in the ack cycle.
REQ-012 err  output  1  high together with an ack when the transaction timed out.
REQ-013 mem_rd / mem_wr  output  1  main-memory read / write strobes.
REQ-014 mem_addr  output  32; mem_wdata  output  BW; mem_rdata  input  BW; mem_ready  input  1  memory completion.

Function
REQ-015 FSM states: IDLE, READ, WRITE, RESP.
REQ-016 In IDLE, a pending request is one of: i_rd, d_rd, or d_wr.
REQ-017 In IDLE, the arbiter picks one pending requester and latches its addr, wdata and operation; the next state is WRITE if d_wr was latched, else READ.
REQ-018 mem_rd is high exactly while in READ; mem_wr is high exactly while in WRITE; mem_addr and mem_wdata are driven from the latched values, stable for the whole state.
REQ-019 mem_ready sampled high in READ: mem_rdata is captured into rdata, next state RESP.
REQ-020 mem_ready sampled high in WRITE: if d_rd was also latched, next state READ at the same address; otherwise next state RESP.
REQ-021 D-cache with d_wr and d_rd both high forms one transaction: write then read, one d_ack at the end.
REQ-022 RESP lasts one cycle: the granted requester's ack is high, then the FSM returns to IDLE.
REQ-023 A requester holds its request and address stable until its ack, and drops them in the cycle after the ack.
REQ-024 The arbiter ignores requests during RESP; a request still high in the following IDLE cycle is a new request.
REQ-025 Minimum latency: request first seen in IDLE at cycle N, mem strobe in N+1, mem_ready in N+1, ack in N+2.
REQ-026 The timeout counter clears on entry to READ or WRITE and increments each cycle mem_ready is low.
REQ-027 When the timeout counter reaches Timeout: drop the strobe, go to RESP, assert the ack with err=1, leave rdata unchanged, and skip the pending read of a write+read.
REQ-028 err is low in every non-timeout RESP cycle.
REQ-029 mem_ready is ignored in IDLE and RESP.
REQ-030 No new grant is made while a transaction is outstanding; the other requester waits and is not lost.

Reset
REQ-031 While reset is high at a clock edge:
- state := IDLE; all acks, err, mem_rd and mem_wr := 0;
- rdata, mem_addr and mem_wdata := 0;
- timeout counter := 0; round-robin pointer := "last grant was I".
REQ-032 Reset mid-transaction abandons the transaction without an ack; strobes are low in the cycle after the reset edge.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are pending, the requester not granted last wins; the pointer updates at each grant.
- Undefined: the D-cache always wins a tie, and no pointer register exists.
REQ-034 With either setting, a lone pending requester is granted immediately.

Verification
REQ-035 i_rd, addr 0x10, mem_ready one cycle after mem_rd, mem_rdata 0xAAAA... -> one i_ack pulse 3 cycles after the request, rdata 0xAAAA..., err 0.
REQ-036 d_wr+d_rd, addr 0xFF0, wdata 0x77 -> mem_wr with data 0x77 until ready, then mem_rd at 0xFF0, then a single d_ack, no i_ack.
REQ-037 i_rd and d_rd raised in the same cycle, three back-to-back rounds -> macro defined: grants D, I, D; macro undefined: grants D, D, D (I served once D idles).
REQ-038 d_rd with mem_ready held low -> mem_rd high for Timeout cycles, then d_ack with err=1, rdata unchanged.
REQ-039 reset pulsed during READ -> mem_rd low in the next cycle, no ack, state IDLE; a following i_rd completes normally.
REQ-040 i_rd granted, d_rd raised mid-transaction -> i_ack first, d_ack on a later transaction, each with its own rdata.
